// File: rtl/diff_arch_event_pkg.sv
// Shared types for the arch-event batcher: flag bit positions, payload and record layout.
// Macro DIFF_ARCH_EVENT_TIMESTAMP_EN adds a 64-bit capture timestamp to every record.
package diff_arch_event_pkg;

    localparam int FLAG_IR_TO_VS      = 0;
    localparam int FLAG_IR_TO_HS      = 1;
    localparam int FLAG_HVICTL_INJECT = 2;
    localparam int FLAG_HAS_NMI       = 3;

    // Record fields are sized for the largest supported configuration (8 channels).
    localparam int CHAN_W    = 3;
    localparam int REC_SEQ_W = 16;

    typedef struct packed {
        logic [31:0] interrupt;
        logic [31:0] exception;
        logic [63:0] exception_pc;
        logic [31:0] exception_inst;
        logic [3:0]  flags;
        logic [7:0]  coreid;
    } event_payload_t;

    typedef struct packed {
`ifdef DIFF_ARCH_EVENT_TIMESTAMP_EN
        logic [63:0]          timestamp;
`endif
        event_payload_t       payload;
        logic [CHAN_W-1:0]    chan;
        logic [REC_SEQ_W-1:0] seq;
    } arch_event_rec_t;

    localparam int REC_W = $bits(arch_event_rec_t);

endpackage

// File: rtl/diff_arch_event_fifo.sv
// Synchronous FIFO with extra-MSB pointers; caller guarantees push only when not full or popping.
module diff_arch_event_fifo #(
    parameter int  DEPTH = 8,
    parameter type T     = logic [7:0]
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  T                       wdata,
    output T                       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    T           mem [DEPTH];
    logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push) wptr_d = wptr_q + (AW+1)'(1);
        if (pop)  rptr_d = rptr_q + (AW+1)'(1);
        if (flush) begin
            wptr_d = '0;
            rptr_d = '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage needs no reset: entries are only observable between push and pop.
    always_ff @(posedge clock) begin
        if (push && !flush) mem[wptr_q[AW-1:0]] <= wdata;
    end

    assign rdata = mem[rptr_q[AW-1:0]];
    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign count = wptr_q - rptr_q;

endmodule

// File: rtl/diff_arch_event_batcher.sv
// Collects per-channel arch events into skid registers, round-robins them into a FIFO, streams records out.
// Macro DIFF_ARCH_EVENT_TIMESTAMP_EN samples a free-running cycle counter into each captured event.
module diff_arch_event_batcher
    import diff_arch_event_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int DEPTH  = 8,
    parameter int SEQ_W  = 16,
    parameter int DROP_W = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   flush,
    input  logic [NUM_CH-1:0]      ch_valid,
    input  logic [NUM_CH*32-1:0]   ch_interrupt,
    input  logic [NUM_CH*32-1:0]   ch_exception,
    input  logic [NUM_CH*64-1:0]   ch_exception_pc,
    input  logic [NUM_CH*32-1:0]   ch_exception_inst,
    input  logic [NUM_CH*4-1:0]    ch_flags,
    input  logic [NUM_CH*8-1:0]    ch_coreid,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [REC_W-1:0]       out_record,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic [DROP_W-1:0]      drop_count,
    output logic                   overflow
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    arch_event_rec_t [NUM_CH-1:0] skid_q, skid_d;
    logic [NUM_CH-1:0]            skid_vld_q, skid_vld_d;
    logic [CH_W-1:0]              rr_ptr_q, rr_ptr_d, gnt_idx;
    logic [SEQ_W-1:0]             seq_q, seq_d;
    logic [DROP_W-1:0]            drop_cnt_q, drop_cnt_d;
    logic                         overflow_q, overflow_d;
    logic                         gnt_any, grant, pop, fifo_full, fifo_empty;
    logic [3:0]                   n_drop;
    logic [DROP_W+3:0]            drop_sum;
    arch_event_rec_t              push_rec, head_rec;

`ifdef DIFF_ARCH_EVENT_TIMESTAMP_EN
    logic [63:0] ts_q, ts_d;
    assign ts_d = ts_q + 64'd1;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) ts_q <= '0;
        else        ts_q <= ts_d;
    end
`endif

    // First full skid at or after the pointer wins.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (!gnt_any && skid_vld_q[(int'(rr_ptr_q) + k) % NUM_CH]) begin
                gnt_any = 1'b1;
                gnt_idx = CH_W'((int'(rr_ptr_q) + k) % NUM_CH);
            end
        end
    end

    assign pop   = out_valid && out_ready && !flush;
    assign grant = gnt_any && (!fifo_full || pop) && !flush;

    always_comb begin
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;
        n_drop     = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant && gnt_idx == CH_W'(i)) skid_vld_d[i] = 1'b0;
            // A skid freed by this cycle's grant can take the new event.
            if (enable && ch_valid[i] && !flush) begin
                if (!skid_vld_d[i]) begin
                    skid_vld_d[i]                     = 1'b1;
                    skid_d[i]                         = '0;
                    skid_d[i].payload.interrupt       = ch_interrupt[i*32 +: 32];
                    skid_d[i].payload.exception       = ch_exception[i*32 +: 32];
                    skid_d[i].payload.exception_pc    = ch_exception_pc[i*64 +: 64];
                    skid_d[i].payload.exception_inst  = ch_exception_inst[i*32 +: 32];
                    skid_d[i].payload.flags           = ch_flags[i*4 +: 4];
                    skid_d[i].payload.coreid          = ch_coreid[i*8 +: 8];
`ifdef DIFF_ARCH_EVENT_TIMESTAMP_EN
                    skid_d[i].timestamp               = ts_q;
`endif
                end else begin
                    n_drop = n_drop + 4'd1;
                end
            end
        end
        if (flush) skid_vld_d = '0;
    end

    always_comb begin
        push_rec      = skid_q[gnt_idx];
        push_rec.chan = CHAN_W'(gnt_idx);
        push_rec.seq  = REC_SEQ_W'(seq_q);
    end

    always_comb begin
        drop_sum   = (DROP_W+4)'(drop_cnt_q) + (DROP_W+4)'(n_drop);
        drop_cnt_d = (drop_sum > (DROP_W+4)'({DROP_W{1'b1}})) ? '1 : drop_sum[DROP_W-1:0];
        overflow_d = overflow_q || (n_drop != 4'd0);
        seq_d      = grant ? seq_q + SEQ_W'(1) : seq_q;
        rr_ptr_d   = grant ? CH_W'((int'(gnt_idx) + 1) % NUM_CH) : rr_ptr_q;
        if (flush) begin
            drop_cnt_d = '0;
            overflow_d = 1'b0;
            seq_d      = '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            skid_q     <= '0;
            skid_vld_q <= '0;
            rr_ptr_q   <= '0;
            seq_q      <= '0;
            drop_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            skid_q     <= skid_d;
            skid_vld_q <= skid_vld_d;
            rr_ptr_q   <= rr_ptr_d;
            seq_q      <= seq_d;
            drop_cnt_q <= drop_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    diff_arch_event_fifo #(
        .DEPTH (DEPTH),
        .T     (arch_event_rec_t)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .flush (flush),
        .push  (grant),
        .pop   (pop),
        .wdata (push_rec),
        .rdata (head_rec),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Memory is not reset, so the record is masked while the FIFO is empty.
    always_comb begin
        out_record = '0;
        if (!fifo_empty) out_record = head_rec;
    end

    assign out_valid  = !fifo_empty;
    assign drop_count = drop_cnt_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_diff_arch_event_batcher.sv
// Directed bench for diff_arch_event_batcher (NUM_CH=2, DEPTH=8): capture, RR order, back-pressure, flush, seq wrap, reset.
module tb_diff_arch_event_batcher;
    import diff_arch_event_pkg::*;

    logic          clock, reset, enable, flush, out_ready, out_valid, overflow;
    logic [1:0]    ch_valid;
    logic [63:0]   ch_interrupt, ch_exception, ch_exception_inst;
    logic [127:0]  ch_exception_pc;
    logic [7:0]    ch_flags;
    logic [15:0]   ch_coreid;
    logic [REC_W-1:0] out_record;
    logic [3:0]    fifo_count;
    logic [15:0]   drop_count;

    arch_event_rec_t r;
    int n_checks = 0;
    int n_err    = 0;
    int nrec;
    bit done;

    diff_arch_event_batcher #(.NUM_CH(2), .DEPTH(8), .SEQ_W(16), .DROP_W(16)) dut (
        .clock(clock), .reset(reset), .enable(enable), .flush(flush),
        .ch_valid(ch_valid), .ch_interrupt(ch_interrupt), .ch_exception(ch_exception),
        .ch_exception_pc(ch_exception_pc), .ch_exception_inst(ch_exception_inst),
        .ch_flags(ch_flags), .ch_coreid(ch_coreid),
        .out_valid(out_valid), .out_ready(out_ready), .out_record(out_record),
        .fifo_count(fifo_count), .drop_count(drop_count), .overflow(overflow)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic put(input int ch, input logic [31:0] exc, input logic [63:0] pc);
        ch_valid[ch]                  = 1'b1;
        ch_exception[ch*32 +: 32]     = exc;
        ch_exception_pc[ch*64 +: 64]  = pc;
        ch_interrupt[ch*32 +: 32]     = 32'h0;
        ch_exception_inst[ch*32 +: 32] = 32'h0000_0073 + exc;
        ch_flags[ch*4 +: 4]           = 4'(ch + 1);
        ch_coreid[ch*8 +: 8]          = 8'(ch);
    endtask

    task automatic expect_rec(input string tag, input int chan, input int seq, input int exc);
        r = out_record;
        chk({tag, "_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_chan"},  64'(r.chan), 64'(chan));
        chk({tag, "_seq"},   64'(r.seq), 64'(seq));
        chk({tag, "_exc"},   64'(r.payload.exception), 64'(exc));
    endtask

    initial begin
        reset = 1'b0; enable = 1'b1; flush = 1'b0; out_ready = 1'b1; ch_valid = '0;
        ch_interrupt = '0; ch_exception = '0; ch_exception_pc = '0;
        ch_exception_inst = '0; ch_flags = '0; ch_coreid = '0;
        tick(); tick();
        chk("rst_valid",    64'(out_valid), 64'd0);
        chk("rst_record",   64'(out_record[63:0]), 64'd0);
        chk("rst_count",    64'(fifo_count), 64'd0);
        chk("rst_drop",     64'(drop_count), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        reset = 1'b1;
        tick();

        // Single event: visible two cycles after being presented.
        put(0, 32'd2, 64'h8000_0010);
        tick(); ch_valid = '0;
        chk("t1_early_valid", 64'(out_valid), 64'd0);
        tick();
        expect_rec("t1", 0, 0, 2);
        chk("t1_pc",    r.payload.exception_pc, 64'h8000_0010);
        chk("t1_count", 64'(fifo_count), 64'd1);
        tick();
        chk("t1_drained", 64'(out_valid), 64'd0);
        chk("t1_rec_zero", 64'(out_record[63:0]), 64'd0);

        // Flush resets seq; RR pointer is now 1 after the ch0 grant, so ch1 wins the collision.
        flush = 1'b1; tick(); flush = 1'b0;
        put(0, 32'd5, 64'h100); put(1, 32'd7, 64'h200);
        tick(); ch_valid = '0;
        tick();
        expect_rec("t2a", 1, 0, 7);
        tick();
        expect_rec("t2b", 0, 1, 5);
        tick();
        chk("t2_drained", 64'(out_valid), 64'd0);

        // ch1 alone moves the pointer to 0, so the next collision serves ch0 first.
        put(1, 32'd9, 64'h300);
        tick(); ch_valid = '0;
        tick();
        expect_rec("t2c", 1, 2, 9);
        tick();
        put(0, 32'hA, 64'h400); put(1, 32'hB, 64'h500);
        tick(); ch_valid = '0;
        tick();
        expect_rec("t2d", 0, 3, 32'hA);
        tick();
        expect_rec("t2e", 1, 4, 32'hB);
        tick();

        // Back-pressure: 12 back-to-back events fill FIFO (8) and skid (1), drop 3.
        flush = 1'b1; tick(); flush = 1'b0;
        out_ready = 1'b0;
        for (int k = 0; k < 12; k++) begin
            put(0, 32'(k), 64'h1000 + 64'(k));
            tick();
        end
        ch_valid = '0;
        chk("t3_count",    64'(fifo_count), 64'd8);
        chk("t3_drop",     64'(drop_count), 64'd3);
        chk("t3_overflow", 64'(overflow), 64'd1);
        expect_rec("t3_head", 0, 0, 0);

        // Full FIFO: pop and skid push in the same cycle keep the count at 8.
        out_ready = 1'b1;
        tick();
        chk("t4_count", 64'(fifo_count), 64'd8);
        chk("t4_drop",  64'(drop_count), 64'd3);
        // Drain with enable low: channel strobes must be ignored.
        enable = 1'b0;
        put(0, 32'd99, 64'h0);
        for (int k = 1; k <= 8; k++) begin
            expect_rec("t4_drain", 0, k, k);
            tick();
        end
        chk("t4_empty_valid", 64'(out_valid), 64'd0);
        chk("t4_empty_count", 64'(fifo_count), 64'd0);
        ch_valid = '0; enable = 1'b1;

        // Flush with 5 queued and ch0 presenting: everything cleared, event not recorded.
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            put(0, 32'(20 + k), 64'h2000);
            tick();
        end
        ch_valid = '0;
        tick();
        chk("t5_pre_count", 64'(fifo_count), 64'd5);
        flush = 1'b1; put(0, 32'h55, 64'h3000);
        tick();
        flush = 1'b0; ch_valid = '0;
        chk("t5_count",    64'(fifo_count), 64'd0);
        chk("t5_valid",    64'(out_valid), 64'd0);
        chk("t5_drop",     64'(drop_count), 64'd0);
        chk("t5_overflow", 64'(overflow), 64'd0);
        out_ready = 1'b1;
        tick(); tick();
        chk("t5_not_recorded", 64'(out_valid), 64'd0);

        // Sequence wrap: stream one record per cycle past 65536 records.
        put(0, 32'd1, 64'h4000);
        nrec = 0; done = 1'b0;
        for (int c = 0; c < 70000 && !done; c++) begin
            tick();
            if (out_valid) begin
                r = out_record;
                if (nrec == 65535) chk("t6_seq_ffff", 64'(r.seq), 64'hFFFF);
                if (nrec == 65536) begin
                    chk("t6_seq_wrap", 64'(r.seq), 64'h0);
                    done = 1'b1;
                end
                nrec++;
            end
        end
        if (!done) begin
            n_checks++; n_err++;
            $error("FAIL t6_timeout: observed %0d records expected 65537", nrec);
        end
        ch_valid = '0;
        chk("t6_drop", 64'(drop_count), 64'd0);

        // Asynchronous reset with traffic in flight.
        out_ready = 1'b0;
        put(0, 32'd3, 64'h5000);
        tick(); tick(); tick();
        ch_valid = '0;
        chk("t7_pre_valid", 64'(out_valid), 64'd1);
        reset = 1'b0;
        #1;
        chk("t7_valid", 64'(out_valid), 64'd0);
        chk("t7_count", 64'(fifo_count), 64'd0);
        chk("t7_drop",  64'(drop_count), 64'd0);
        tick(); reset = 1'b1; tick(); tick();
        chk("t7_post_valid", 64'(out_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
